misr_ora: RTL and testbench
===========================

# misr_ora

Parametrised multiple-input signature register with a built-in output-response-analyser controller. It generalises the 4-bit serial SISR in width, polynomial, seed and input count. It adds a length-bounded compaction window, a valid-qualified input stream, and a registered pass/fail compare against a golden signature. It sits at the output of the circuit under test in the BIST datapath, downstream of the pattern generator, and reports to the BIST controller.

## Interface
Parameters:
- WIDTH, 16: signature register width; legal range 2..64.
- POLY, 16'h002D: feedback tap mask. Bit i set means the feedback bit is XORed into stage i.
- N_IN, 1: number of parallel response inputs; legal range 1..WIDTH.
- SEED, 0: signature value loaded at reset and at start.
- CNT_W, 16: width of the compaction length counter.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a compaction window; sampled only in IDLE or DONE.
- len, in, CNT_W: number of valid beats to compact; sampled with start.
- in_valid, in, 1: d_in carries a response beat this cycle.
- d_in, in, N_IN: response bits from the circuit under test.
- golden, in, WIDTH: expected signature; sampled on the RUN→DONE edge.
- busy, out, 1: high in RUN.
- done, out, 1: high in DONE, held until the next start.
- pass, out, 1: signature equalled golden; valid only while done=1.
- signature, out, WIDTH: current register contents.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - sig←SEED, cnt←len, pass←0.
  - If len==0, next state is DONE and pass←(SEED==golden).
  - Otherwise next state is RUN.
- RUN with in_valid=1:
  - Perform one compaction step and set cnt←cnt−1.
  - When cnt==1, next state is DONE and pass←(next sig == golden).
- RUN with in_valid=0: hold all state.
- start in RUN is ignored; there is no abort. reset_n is the only way out of RUN.
- Compaction step (right-shifting internal-XOR form):
  - fb = sig[0].
  - nxt[i] = sig[i+1] ^ (POLY[i] & fb) ^ e[i] for i < WIDTH−1.
  - nxt[WIDTH−1] = (POLY[WIDTH−1] & fb) ^ e[WIDTH−1].
- Input placement: e[WIDTH−N_IN+j] = d_in[j]; all other e bits are 0. With N_IN=1 the serial input enters the MSB.
- Legacy equivalence: WIDTH=4, POLY=4'b1011, N_IN=1, SEED=0 is bit-exact with the legacy SISR, x⁴+x³+x²+1.
- d_in is ignored outside RUN and when in_valid=0.
- The counter is unsigned CNT_W bits and never wraps: it stops at the DONE transition.

## Timing
- Reset values: signature=SEED, busy=0, done=0, pass=0, state IDLE.
- The reset assertion is asynchronous; deassertion must be synchronised externally.
- start→busy: 1 cycle.
- Each valid beat updates signature on the same rising edge.
- Last valid beat → done=1 and pass valid on the following cycle. signature is final at that point and then held.
- A window of len beats takes len + 1 cycles minimum from start when in_valid is continuously high.
- start in DONE: done drops and busy rises the next cycle; there are no idle cycles between windows.
- reset_n asserted mid-RUN: immediate return to reset values; the partial signature is discarded.

## Configuration
- MISR_ORA_XMASK_EN defined:
  - Adds input port in_mask, width N_IN.
  - Bits set in in_mask force the corresponding d_in bit to 0 before compaction, for X-masking of unknown responses.
  - in_mask is sampled together with in_valid.
- MISR_ORA_XMASK_EN undefined: the port is absent and every d_in bit is compacted.

## Structure
- Package misr_pkg holds:
  - the state enum, encoded IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the named polynomial constants POLY4_LEGACY=4'b1011, POLY16_DEFAULT, POLY32_DEFAULT.
- Sub-module misr_step: purely combinational, computes nxt from (sig, e) with parameters WIDTH, POLY and N_IN.
- The top level holds the FSM, the counter, the registers and the compare.

## Test plan
- Legacy configuration (WIDTH=4, POLY=4'b1011, N_IN=1): start, len=5, serial stream 1,0,0,0,0 → signature 4'b1011 and done=1. With golden=4'b1011, pass=1; with golden=4'b0001, pass=0.
- Same configuration, stream 1,0,0,0 with len=4 → signature 4'b0001 after the fourth beat; no step occurs during in_valid=0 gaps inserted between beats.
- len=0: start → done=1 one cycle later with signature=SEED. pass=1 when golden=SEED.
- Back-to-back: start asserted while done=1 → signature reloads SEED and busy=1 on the next cycle. A second window with identical data reproduces the identical signature.
- reset_n pulsed low after 3 of 10 beats → signature=SEED, busy=0, done=0 asynchronously. A fresh window afterwards matches the reference model.
- MISR_ORA_XMASK_EN defined, WIDTH=16, N_IN=8: random d_in with in_mask=8'hFF on all beats → final signature equals the all-zero-input signature. Random in_mask → matches the reference model over 1000 beats.

Source files
------------

// File: rtl/misr_pkg.sv
// misr_pkg: shared types and constants for the MISR output-response analyser.
//   misr_state_e   - controller state encoding (IDLE, RUN, DONE)
//   POLY4_LEGACY   - tap mask matching the legacy 4-bit SISR, x^4+x^3+x^2+1
//   POLY16_DEFAULT - default 16-bit tap mask
//   POLY32_DEFAULT - default 32-bit tap mask
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_e;

    localparam logic [3:0]  POLY4_LEGACY   = 4'b1011;
    localparam logic [15:0] POLY16_DEFAULT = 16'h002D;
    localparam logic [31:0] POLY32_DEFAULT = 32'h0000_00AF;

endpackage

// File: rtl/misr_step.sv
// misr_step: one combinational compaction step of a right-shifting,
// internal-XOR signature register.
//   sig [WIDTH]  in  - current signature
//   d   [N_IN]   in  - response bits, placed in the top N_IN bits of the register
//   nxt [WIDTH]  out - signature after the step
module misr_step
    import misr_pkg::*;
#(
    parameter int unsigned         WIDTH = 16,
    parameter logic [WIDTH-1:0]    POLY  = WIDTH'(POLY16_DEFAULT),
    parameter int unsigned         N_IN  = 1
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [N_IN-1:0]  d,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] e;

    // Parallel inputs occupy the MSB end so a serial input enters at the top.
    always_comb begin
        e = '0;
        e[WIDTH-1 -: N_IN] = d;
    end

    // Feedback is the bit shifted out of stage 0, folded back through the taps.
    assign nxt = {1'b0, sig[WIDTH-1:1]} ^ (POLY & {WIDTH{sig[0]}}) ^ e;

endmodule

// File: rtl/misr_ora.sv
// misr_ora: parametrised MISR with a length-bounded compaction window and a
// registered pass/fail compare against a golden signature.
//   clk, reset_n     - clock (rising edge), asynchronous active-low reset
//   start, len       - open a window of len valid beats (accepted in IDLE/DONE)
//   in_valid, d_in   - response stream from the circuit under test
//   in_mask          - per-bit X-mask, present only with MISR_ORA_XMASK_EN
//   golden           - expected signature, sampled as the window closes
//   busy, done, pass - status; pass is meaningful only while done=1
//   signature        - current register contents
// Optional feature macro: MISR_ORA_XMASK_EN.
module misr_ora
    import misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY16_DEFAULT),
    parameter int unsigned      N_IN  = 1,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  d_in,
`ifdef MISR_ORA_XMASK_EN
    input  logic [N_IN-1:0]  in_mask,
`endif
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    misr_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [N_IN-1:0]  d_eff;
    logic [WIDTH-1:0] sig_nxt;

`ifdef MISR_ORA_XMASK_EN
    // Masked bits are forced to 0 so unknown responses cannot corrupt the signature.
    assign d_eff = d_in & ~in_mask;
`else
    assign d_eff = d_in;
`endif

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .N_IN  (N_IN)
    ) u_step (
        .sig (sig_q),
        .d   (d_eff),
        .nxt (sig_nxt)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d  = SEED;
                    cnt_d  = len;
                    pass_d = 1'b0;
                    if (len == '0) begin
                        // Empty window: the seed itself is the signature.
                        state_d = DONE;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    sig_d = sig_nxt;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        pass_d  = (sig_nxt == golden);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_misr_ora.sv
// tb_misr_ora: self-checking bench for misr_ora. A legacy 4-bit instance and a
// 16-bit, 8-input instance are driven with randomised windows and compared with
// a behavioural signature model.
module tb_misr_ora;

    localparam logic [15:0] W_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Legacy instance
    logic        l_start = 1'b0, l_valid = 1'b0, l_d = 1'b0;
    logic [15:0] l_len = '0;
    logic [3:0]  l_golden = '0, l_sig;
    logic        l_busy, l_done, l_pass;

    // Wide instance
    logic        w_start = 1'b0, w_valid = 1'b0;
    logic [7:0]  w_d = '0;
    logic [15:0] w_len = '0;
    logic [15:0] w_golden = '0, w_sig;
    logic        w_busy, w_done, w_pass;
`ifdef MISR_ORA_XMASK_EN
    logic [7:0]  w_mask = '0;
    logic        l_mask = 1'b0;
`endif

    misr_ora #(
        .WIDTH (4),
        .POLY  (4'b1011),
        .N_IN  (1),
        .SEED  (4'h0),
        .CNT_W (16)
    ) dut_legacy (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (l_start),
        .len       (l_len),
        .in_valid  (l_valid),
        .d_in      (l_d),
`ifdef MISR_ORA_XMASK_EN
        .in_mask   (l_mask),
`endif
        .golden    (l_golden),
        .busy      (l_busy),
        .done      (l_done),
        .pass      (l_pass),
        .signature (l_sig)
    );

    misr_ora #(
        .WIDTH (16),
        .POLY  (16'h002D),
        .N_IN  (8),
        .SEED  (W_SEED),
        .CNT_W (16)
    ) dut_wide (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (w_start),
        .len       (w_len),
        .in_valid  (w_valid),
        .d_in      (w_d),
`ifdef MISR_ORA_XMASK_EN
        .in_mask   (w_mask),
`endif
        .golden    (w_golden),
        .busy      (w_busy),
        .done      (w_done),
        .pass      (w_pass),
        .signature (w_sig)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature as a polynomial-division remainder: divide by x (shift right),
    // fold in the tap mask when a 1 falls off, then add the new input word at the top.
    function automatic logic [63:0] step_ref(input logic [63:0] s, input logic [63:0] d,
                                             input int w, input int n, input logic [63:0] poly);
        logic [63:0] r;
        logic [63:0] wmask;
        wmask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = (s >> 1) ^ (s[0] ? poly : 64'd0) ^ (d << (w - n));
        return r & wmask;
    endfunction

    // Legacy window: bits[k] is beat k; optional in_valid gaps between beats.
    task automatic l_window(input int len, input logic [15:0] bits, input bit gaps,
                            input logic [3:0] gold, input string tag, output logic [3:0] sig_out);
        logic [63:0] exp;
        int beats;
        bit last_gap;
        exp = 64'd0;
        beats = 0;
        last_gap = 1'b0;
        @(negedge clk);
        l_start = 1'b1;
        l_len = 16'(len);
        l_golden = gold;
        @(negedge clk);
        l_start = 1'b0;
        check_eq({tag, "_busy"}, l_busy, 1);
        check_eq({tag, "_done_low"}, l_done, 0);
        check_eq({tag, "_seed"}, l_sig, 0);
        while (beats < len) begin
            check_eq({tag, "_run_sig"}, l_sig, exp);
            if (gaps && beats > 0 && !last_gap && (beats == 2 || $urandom_range(1) == 1)) begin
                l_valid = 1'b0;
                l_d = 1'($urandom);
                last_gap = 1'b1;
            end else begin
                l_valid = 1'b1;
                l_d = bits[beats];
                exp = step_ref(exp, 64'(bits[beats]), 4, 1, 64'hB);
                beats++;
                last_gap = 1'b0;
            end
            @(negedge clk);
        end
        l_valid = 1'b0;
        check_eq({tag, "_done"}, l_done, 1);
        check_eq({tag, "_busy_low"}, l_busy, 0);
        check_eq({tag, "_sig"}, l_sig, exp);
        check_eq({tag, "_pass"}, l_pass, 64'(exp[3:0] == gold));
        sig_out = exp[3:0];
    endtask

    // Wide window: random data and gaps. mask_mode 0=none, 1=all masked, 2=random mask.
    task automatic w_window(input int len, input int mask_mode, input string tag);
        logic [63:0] exp, zero_sig;
        logic [7:0]  d, m;
        int beats;
        bit good;
        exp = 64'(W_SEED);
        zero_sig = 64'(W_SEED);
        beats = 0;
        good = 1'($urandom);
        @(negedge clk);
        w_start = 1'b1;
        w_len = 16'(len);
        w_golden = 16'($urandom);
        @(negedge clk);
        w_start = 1'b0;
        check_eq({tag, "_busy"}, w_busy, 1);
        check_eq({tag, "_seed"}, w_sig, 64'(W_SEED));
        while (beats < len) begin
            d = 8'($urandom);
            m = (mask_mode == 1) ? 8'hFF : (mask_mode == 2) ? 8'($urandom) : 8'h00;
            w_d = d;
`ifdef MISR_ORA_XMASK_EN
            w_mask = m;
`else
            m = 8'h00;
`endif
            if ($urandom_range(3) == 0) begin
                w_valid = 1'b0;
            end else begin
                w_valid = 1'b1;
                exp = step_ref(exp, 64'(d & ~m), 16, 8, 64'h002D);
                zero_sig = step_ref(zero_sig, 64'd0, 16, 8, 64'h002D);
                beats++;
                if (beats == len) begin
                    w_golden = good ? exp[15:0] : (exp[15:0] ^ (16'd1 << $urandom_range(15)));
                end
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
        check_eq({tag, "_done"}, w_done, 1);
        check_eq({tag, "_sig"}, w_sig, exp);
        check_eq({tag, "_pass"}, w_pass, 64'(good));
        if (mask_mode == 1) check_eq({tag, "_zero_sig"}, w_sig, zero_sig);
    endtask

    initial begin
        logic [3:0] s1, s2;
        logic [63:0] exp;

        // Reset values
        #12;
        check_eq("rst_l_sig", l_sig, 0);
        check_eq("rst_l_busy", l_busy, 0);
        check_eq("rst_l_done", l_done, 0);
        check_eq("rst_l_pass", l_pass, 0);
        check_eq("rst_w_sig", w_sig, 64'(W_SEED));
        @(negedge clk);
        reset_n = 1'b1;

        // Legacy stream 1,0,0,0,0
        l_window(5, 16'b00001, 1'b0, 4'b1011, "leg5_good", s1);
        check_eq("leg5_const", s1, 4'b1011);
        check_eq("leg5_pass1", l_pass, 1);
        // Back-to-back from DONE, identical data, mismatching golden
        l_window(5, 16'b00001, 1'b0, 4'b0001, "leg5_bad", s2);
        check_eq("b2b_same_sig", s2, 64'(s1));
        check_eq("leg5_pass0", l_pass, 0);

        // Stream 1,0,0,0 with gaps
        l_window(4, 16'b0001, 1'b1, 4'b0001, "leg4_gap", s1);
        check_eq("leg4_const", s1, 4'b0001);

        // Empty window
        @(negedge clk);
        l_start = 1'b1;
        l_len = 16'd0;
        l_golden = 4'h0;
        @(negedge clk);
        l_start = 1'b0;
        check_eq("len0_done", l_done, 1);
        check_eq("len0_busy", l_busy, 0);
        check_eq("len0_sig", l_sig, 0);
        check_eq("len0_pass", l_pass, 1);

        // Reset after 3 of 10 beats
        @(negedge clk);
        l_start = 1'b1;
        l_len = 16'd10;
        @(negedge clk);
        l_start = 1'b0;
        l_d = 1'b1;
        l_valid = 1'b1;
        repeat (3) @(negedge clk);
        l_valid = 1'b0;
        check_eq("pre_rst_busy", l_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_sig", l_sig, 0);
        check_eq("async_rst_busy", l_busy, 0);
        check_eq("async_rst_done", l_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        l_window(10, 16'($urandom), 1'b1, 4'($urandom), "leg_after_rst", s1);

        // Wide instance
        for (int i = 0; i < 4; i++) w_window(20 + i * 7, 0, "wide_rand");
`ifdef MISR_ORA_XMASK_EN
        w_window(30, 1, "wide_allmask");
        w_window(1000, 2, "wide_randmask");
`else
        w_window(300, 0, "wide_long");
`endif

        // Held in DONE with no start
        exp = 64'(w_sig);
        repeat (3) @(negedge clk);
        check_eq("done_hold_sig", w_sig, exp);
        check_eq("done_hold_done", w_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
